layer6_feeder: RTL and testbench
================================

LAYER6_FEEDER -- requirements
Module: layer6_feeder

Interface
REQ-001 SHALL have parameter N_IN, default 15, meaning number of activations per frame (fan-in of one layer-6 node).
REQ-002 SHALL have parameter SETTLE, default 4, meaning cycles allowed for the combinational float mult/add chain to settle (range 1..255).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset: asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning upstream activation word valid.
REQ-006 SHALL have port in_ready, output, 1, meaning feeder accepts a word this cycle.
REQ-007 SHALL have port in_data, input, 32, meaning IEEE-754 single activation.
REQ-008 SHALL have port in_last, input, 1, meaning final word of the frame.
REQ-009 SHALL have port a_bus, output, N_IN*32, meaning registered activations; word k occupies bits [32k+31:32k] and drives node input Ak.
REQ-010 SHALL have port node_n1, input, 32, meaning ReLU'd node output N1.
REQ-011 SHALL have port res_valid, output, 1, meaning res_data holds a captured result.
REQ-012 SHALL have port res_ready, input, 1, meaning downstream accepts the result.
REQ-013 SHALL have port res_data, output, 32, meaning captured node_n1.
REQ-014 SHALL have port len_err, output, 1, meaning the current frame was short or overlong; valid with res_valid.

Function
REQ-015 SHALL implement the FSM states FILL, SETTLE and HOLD.
REQ-016 SHALL, in FILL: drive in_ready=1; on in_valid&&in_ready, write in_data to slot idx and increment idx.
REQ-017 SHALL leave FILL when in_last is accepted, or when slot N_IN-1 is written, whichever occurs first.
REQ-018 SHALL, on a short frame (in_last accepted at idx<N_IN-1), write 32'h00000000 to all remaining slots in the same edge and set len_err.
REQ-019 SHALL, on an overlong frame (slot N_IN-1 written without in_last), set len_err, go to SETTLE, and discard further words until in_last is accepted.
REQ-020 SHALL drop discarded words with in_ready=1, with no effect on a_bus.
REQ-021 SHALL, in SETTLE: hold in_ready=0 (except while discarding), count SETTLE cycles, then capture node_n1 into res_data, assert res_valid and enter HOLD.
REQ-022 SHALL keep a_bus stable through SETTLE and HOLD.
REQ-023 SHALL, in HOLD: keep res_valid=1 and res_data constant until res_valid&&res_ready.
REQ-024 SHALL, on that handshake, clear res_valid, len_err and idx, and return to FILL on the next edge.
REQ-025 SHALL leave in_ready=0 in the handshake cycle itself (no overlap).
REQ-026 SHALL give a full frame a latency of SETTLE+1 cycles from the edge accepting the last word to the res_valid rising edge.
REQ-027 SHALL use an idx counter of width $clog2(N_IN) that never wraps; saturation is handled by REQ-019.
REQ-028 SHALL treat res_data as a passthrough: no arithmetic, sign preserved as received.

Reset
REQ-029 SHALL, on rst_n low, immediately set: state=FILL, idx=0, a_bus all zero, res_data=0, res_valid=0, len_err=0, discard flag=0.
REQ-030 SHALL drive in_ready to 1 after reset deassertion.
REQ-031 SHALL abandon any frame that is mid-fill or mid-settle at reset, producing no result.

Structure
REQ-032 SHALL place WORD_W=32, FP_ZERO=32'h00000000 and the FSM state encoding in the shared package layer_pkg.
REQ-033 SHALL NOT contain the node; node6_x is instantiated alongside it at the layer level.
REQ-034 SHALL contain no sub-module; the settle counter is inline.

Verification
REQ-035 SHALL check: 15 words of 32'h3F800000 (1.0), in_last on the 15th -> res_valid exactly 5 cycles after the last accept; res_data equals node_n1 sampled then; len_err=0.
REQ-036 SHALL check: a 3-word frame -> a_bus slots 3..14 = 0; len_err=1.
REQ-037 SHALL check: an 18-word frame with in_last on word 18 -> words 16-18 are dropped; a_bus holds words 1-15; len_err=1.
REQ-038 SHALL check: res_ready held 0 for 10 cycles -> res_data stable and in_ready=0; after the handshake, in_ready=1 on the following cycle.
REQ-039 SHALL check: rst_n pulsed low during SETTLE -> outputs zero asynchronously; no res_valid follows; the next full frame is processed normally.
REQ-040 SHALL check: in_valid toggled randomly across a full frame -> the same result as the back-to-back case.

Source files
------------

// File: rtl/layer_pkg.sv
// layer_pkg: shared word constants and feeder FSM encoding
package layer_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] FP_ZERO = 32'h00000000;
  typedef enum logic [1:0] {ST_FILL, ST_SETTLE, ST_HOLD} feed_state_t;
endpackage

// File: rtl/layer6_feeder.sv
// layer6_feeder: collects one frame of activations for a layer-6 node, waits for the
// float chain to settle, then captures and holds the node output until taken.
module layer6_feeder
  import layer_pkg::*;
#(
  parameter int N_IN = 15,
  parameter int SETTLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_W-1:0]      in_data,
  input  logic                   in_last,
  output logic [N_IN*WORD_W-1:0] a_bus,
  input  logic [WORD_W-1:0]      node_n1,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WORD_W-1:0]      res_data,
  output logic                   len_err
);
  localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_IN - 1);
  feed_state_t state;
  logic [IW-1:0] idx;
  logic [7:0] cnt;
  logic discard;
  logic take;
  assign in_ready = state == ST_FILL || discard;
  assign take = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_FILL;
      idx <= '0;
      cnt <= '0;
      discard <= 1'b0;
      a_bus <= '0;
      res_data <= '0;
      res_valid <= 1'b0;
      len_err <= 1'b0;
    end else
      case (state)
        ST_FILL:
          if (take) begin
            for (int k = 0; k < N_IN; k++)
              if (IW'(k) == idx) a_bus[k*WORD_W +: WORD_W] <= in_data;
              else if (in_last && IW'(k) > idx) a_bus[k*WORD_W +: WORD_W] <= FP_ZERO;
            if (in_last || idx == LAST) begin
              state <= ST_SETTLE;
              cnt <= '0;
              len_err <= !(in_last && idx == LAST);
              discard <= !in_last;
            end else
              idx <= idx + 1'b1;
          end
        ST_SETTLE: begin
          // overlong tail is swallowed here; capture waits until it has drained
          if (take && in_last) discard <= 1'b0;
          if (cnt != 8'(SETTLE)) cnt <= cnt + 1'b1;
          else if (!discard) begin
            res_data <= node_n1;
            res_valid <= 1'b1;
            state <= ST_HOLD;
          end
        end
        ST_HOLD:
          if (res_ready) begin
            res_valid <= 1'b0;
            len_err <= 1'b0;
            idx <= '0;
            state <= ST_FILL;
          end
        default: state <= ST_FILL;
      endcase
endmodule

// File: tb/tb_layer6_feeder.sv
// tb_layer6_feeder: scoreboard bench; a stand-in node folds a_bus into node_n1.
module tb_layer6_feeder;
  localparam int N = 15;
  localparam int ST = 4;
  localparam int BW = N * 32;
  typedef struct {
    logic [BW-1:0] bus;
    logic          err;
  } exp_t;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, res_ready = 0;
  logic in_ready, res_valid, len_err;
  logic [31:0] in_data = 0, node_n1, res_data;
  logic [BW-1:0] a_bus;
  logic [31:0] fw [0:19];
  exp_t sb[$];
  int n_vec = 0, n_bad = 0, cyc = 0, acc_edge = 0;

  layer6_feeder #(.N_IN(N), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .a_bus(a_bus), .node_n1(node_n1),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .len_err(len_err)
  );

  function automatic logic [31:0] node_model(input logic [BW-1:0] b);
    logic [31:0] r = '0;
    for (int k = 0; k < N; k++) r = {r[30:0], r[31]} ^ b[k*32 +: 32];
    return r;
  endfunction

  assign node_n1 = node_model(a_bus);
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input int n, input bit rnd);
    exp_t e;
    e.bus = '0;
    for (int i = 0; i < n && i < N; i++) e.bus[i*32 +: 32] = fw[i];
    e.err = n != N;
    sb.push_back(e);
    for (int i = 0; i < n; i++) begin
      if (rnd)
        while ($urandom_range(0, 2) == 0) begin
          @(negedge clk);
          in_valid = 0;
        end
      @(negedge clk);
      in_valid = 1;
      in_data = fw[i];
      in_last = i == n - 1;
      for (int t = 0; t < 50 && !in_ready; t++) @(negedge clk);
      chk("in_ready", in_ready, 1);
      acc_edge = cyc + 1;
    end
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic get_result(input bit chk_lat, input int hold);
    exp_t e;
    for (int t = 0; t < 100 && !res_valid; t++) @(negedge clk);
    chk("res_valid", res_valid, 1);
    if (res_valid && sb.size() > 0) begin
      e = sb.pop_front();
      if (chk_lat) chk("latency", cyc - acc_edge, ST + 1);
      chk("a_bus", a_bus, e.bus);
      chk("res_data", res_data, node_model(e.bus));
      chk("len_err", len_err, e.err);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_data", res_data, node_model(e.bus));
        chk("hold_ready", in_ready, 0);
        chk("hold_valid", res_valid, 1);
      end
      res_ready = 1;
      chk("hs_ready", in_ready, 0);
      @(negedge clk);
      res_ready = 0;
      chk("post_valid", res_valid, 0);
      chk("post_ready", in_ready, 1);
      chk("post_err", len_err, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_a_bus", a_bus, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_len_err", len_err, 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    // full frame of 1.0
    for (int i = 0; i < N; i++) fw[i] = 32'h3F800000;
    send_frame(N, 0);
    get_result(1, 2);
    // short frame zero-fills the tail
    for (int i = 0; i < 3; i++) fw[i] = $urandom;
    send_frame(3, 0);
    get_result(0, 0);
    chk("short_tail", a_bus[BW-1:96], 0);
    // single-word frame
    fw[0] = 32'hC0490FDB;
    send_frame(1, 0);
    get_result(0, 0);
    // overlong frame drops words 16..18
    for (int i = 0; i < 18; i++) fw[i] = $urandom;
    send_frame(18, 0);
    get_result(0, 0);
    // negative values, downstream stalls for 10 cycles
    for (int i = 0; i < N; i++) fw[i] = $urandom | 32'h80000000;
    send_frame(N, 0);
    get_result(1, 10);
    // same words with random valid gaps
    send_frame(N, 1);
    get_result(1, 0);
    // reset pulsed mid-settle
    for (int i = 0; i < N; i++) fw[i] = $urandom;
    send_frame(N, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_a_bus", a_bus, 0);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_res_data", res_data, 0);
    chk("arst_len_err", len_err, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen |= res_valid;
    end
    chk("no_result", seen, 0);
    chk("arst_in_ready", in_ready, 1);
    for (int i = 0; i < N; i++) fw[i] = $urandom;
    send_frame(N, 0);
    get_result(1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
